riscv_mc_controller: RTL and testbench
======================================

// Module: riscv_mc_controller
// PURPOSE
//  Control FSM plus main/ALU/immediate decoders for the multicycle RV32I core (lw, sw, R-type, I-ALU, jal, beq).
//  Sits between the instruction register/ALU flags and the datapath muxes/enables.
//  Drives every datapath control, and exports current_state to the bound control-unit checker.
// PARAMETERS
//  (none; encodings are fixed in cpu_ctrl_pkg)
// PORTS
//  clk            in   1  core clock; one clock domain
//  reset          in   1  asynchronous, active-low reset (0 = in reset)
//  op             in   7  instr[6:0]
//  funct3         in   3  instr[14:12]
//  funct7b5       in   1  instr[30]
//  zero           in   1  ALU zero flag, same cycle
//  current_state  out  4  FSM state register, S0=0 .. S10=10
//  PCWrite        out  1  (Branch & zero) | PCUpdate
//  AdrSrc         out  1  0=PC, 1=ALUOut to memory address
//  MemWrite       out  1  data memory write enable
//  IRWrite        out  1  instruction register load
//  RegWrite       out  1  register file write enable
//  ResultSrc      out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA        out  2  00=PC, 01=OldPC, 10=RD1
//  ALUSrcB        out  2  00=RD2, 01=ImmExt, 10=const 4
//  ALUControl     out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc         out  2  00=I, 01=S, 10=B, 11=J
// BEHAVIOUR
//  Reset: state <= S0 asynchronously. While reset=0, PCWrite/IRWrite/MemWrite/RegWrite are forced 0 (gated by reset).
//   All other outputs take their S0 values. First fetch happens on the first posedge after reset deasserts.
//  Outputs are Moore-decoded from state (plus op/funct/zero where noted). 0-cycle combinational; state is the only flop.
//  Transitions, one per posedge:
//   S0 Fetch->S1. S1 Decode: lw/sw->S2, R->S6, I-ALU->S8, jal->S9, beq->S10, other op->S0 (NOP).
//   S2 MemAdr: lw->S3, sw->S5. S3 MemRead->S4. S4 MemWB->S0. S5 MemWrite->S0.
//   S6 ExecR->S7. S8 ExecI->S7. S9 JAL->S7. S7 ALUWB->S0. S10 BEQ->S0.
//   States 11..15 (illegal) -> S0; all enables 0 while there.
//  Per-state outputs (unlisted = 0):
//   S0: IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10
//   S1: ALUSrcA=01, ALUSrcB=01, ALUOp=00   (branch/jump target precompute)
//   S2: ALUSrcA=10, ALUSrcB=01, ALUOp=00
//   S3: AdrSrc=1.  S4: ResultSrc=01, RegWrite=1.  S5: AdrSrc=1, MemWrite=1
//   S6: ALUSrcA=10, ALUSrcB=00, ALUOp=10.  S8: ALUSrcA=10, ALUSrcB=01, ALUOp=10
//   S7: ResultSrc=00, RegWrite=1
//   S9: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
//   S10: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1
//  Invariants: IRWrite only in S0; MemWrite only in S5; RegWrite only in S4/S7; PCWrite only in S0, S9, or S10&zero.
//  ALU decode (ALUOp 2b, internal): 00->add; 01->sub; 10 by funct3:
//   000: sub if (op[5]&funct7b5), else add (addi never subtracts); 010->slt; 110->or; 111->and; others->add.
//  ImmSrc from op, independent of state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, else 00.
//  op/funct may change in any state; they only affect next-state in S1/S2 and ALUControl when ALUOp=10.
//  Reset asserted mid-instruction: immediate return to S0, enables drop the same cycle; no partial write may follow.
// STRUCTURE
//  cpu_ctrl_pkg: state_t enum (S0..S10, 4-bit), opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ),
//   ALUControl codes, ResultSrc/ALUSrc encodings. The checker and datapath import the same package.
//  Sub-module control_alu_decoder (ALUOp, funct3, funct7b5, op5 -> ALUControl), purely combinational.
//  Top: state flop, next-state case, output case, ImmSrc decode, reset gating of enables.
// TESTING
//  1 Hold reset=0 for 3 cycles with op=R -> current_state=0, all four enables 0; release -> S0, S1, S6, S7, S0.
//  2 lw (0000011): S0,S1,S2,S3,S4,S0 -> 5 cycles; RegWrite=1 only in S4 with ResultSrc=01; ImmSrc=00.
//  3 sw (0100011): S0,S1,S2,S5,S0 -> MemWrite=1 only in S5 with AdrSrc=1; ImmSrc=01.
//  4 beq with zero=1 then zero=0 in S10 -> PCWrite=1 then 0; ALUControl=001 in S10.
//  5 R funct3=000 funct7b5=1 -> ALUControl=001 in S6; addi with funct7b5=1 -> 000; funct3=010 -> 101.
//  6 jal -> S9 has PCWrite=1, ALUSrcA=01, ALUSrcB=10; op=0000000 in S1 -> S0.
//   Drop reset in S5 -> MemWrite falls in the same cycle.
//  Bind the control-unit checker throughout; zero assertion failures required.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller, its datapath and its checker.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S0_FETCH    = 4'd0,
    S1_DECODE   = 4'd1,
    S2_MEMADR   = 4'd2,
    S3_MEMREAD  = 4'd3,
    S4_MEMWB    = 4'd4,
    S5_MEMWRITE = 4'd5,
    S6_EXECR    = 4'd6,
    S7_ALUWB    = 4'd7,
    S8_EXECI    = 4'd8,
    S9_JAL      = 4'd9,
    S10_BEQ     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/control_alu_decoder.sv
// ALU operation decode from ALUOp and the instruction function fields.
module control_alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, whose imm[10] lands on funct7b5
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM with main, ALU and immediate decode.
//  state | meaning
//  S0    | fetch, IR load, PC+4
//  S1    | decode, branch/jump target precompute
//  S2    | memory address
//  S3    | memory read
//  S4    | load writeback
//  S5    | memory write
//  S6    | R-type execute
//  S7    | ALU writeback
//  S8    | I-ALU execute
//  S9    | jal
//  S10   | beq
module riscv_mc_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [3:0] current_state,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc
);

  state_t     state, state_n;
  logic [1:0] alu_op;
  logic       pc_update, branch, ir_write_raw, mem_write_raw, reg_write_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S0_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = S0_FETCH;
    case (state)
      S0_FETCH: state_n = S1_DECODE;
      S1_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = S2_MEMADR;
          OP_R:         state_n = S6_EXECR;
          OP_I:         state_n = S8_EXECI;
          OP_JAL:       state_n = S9_JAL;
          OP_BEQ:       state_n = S10_BEQ;
          default:      state_n = S0_FETCH;
        endcase
      end
      S2_MEMADR: begin
        if (op == OP_LW)      state_n = S3_MEMREAD;
        else if (op == OP_SW) state_n = S5_MEMWRITE;
        else                  state_n = S0_FETCH;
      end
      S3_MEMREAD:  state_n = S4_MEMWB;
      S6_EXECR:    state_n = S7_ALUWB;
      S8_EXECI:    state_n = S7_ALUWB;
      S9_JAL:      state_n = S7_ALUWB;
      default:     state_n = S0_FETCH;
    endcase
  end

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    alu_op        = ALUOP_ADD;
    case (state)
      S0_FETCH: begin
        ir_write_raw = 1'b1;
        pc_update    = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
      end
      S1_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S2_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S3_MEMREAD: AdrSrc = 1'b1;
      S4_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S5_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S6_EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S7_ALUWB: reg_write_raw = 1'b1;
      S8_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S9_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S10_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so they drop with it, not at the next edge.
  assign PCWrite  = reset & ((branch & zero) | pc_update);
  assign IRWrite  = reset & ir_write_raw;
  assign MemWrite = reset & mem_write_raw;
  assign RegWrite = reset & reg_write_raw;

  assign current_state = state;

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  control_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench: the driver queues hand-computed per-cycle outputs, the monitor compares.
module tb_riscv_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [3:0] current_state;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  string       name_q[$];
  event        mon_ev;

  riscv_mc_controller dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .current_state (current_state),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUControl    (ALUControl),
    .ImmSrc        (ImmSrc)
  );

  always #5 clk = ~clk;

  // Monitor: one expected record per sample point
  initial begin
    logic [19:0] act, expv;
    string       nm;
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        act  = {current_state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL %s: got %b required %b (st|pcw adr mw irw rw|res|sa|sb|alu|imm)",
                   nm, act, expv);
        end
        checks++;
        if ((IRWrite && current_state != 4'd0) || (MemWrite && current_state != 4'd5) ||
            (RegWrite && !(current_state == 4'd4 || current_state == 4'd7)) ||
            (PCWrite && !(current_state == 4'd0 || current_state == 4'd9 ||
                          current_state == 4'd10))) begin
          errors++;
          $display("FAIL invariant@%s: state %0d pcw %b irw %b mw %b rw %b required enables only in legal states",
                   nm, current_state, PCWrite, IRWrite, MemWrite, RegWrite);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] st, input logic pcw, input logic adr,
                      input logic mw, input logic irw, input logic rw, input logic [1:0] res,
                      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
                      input logic [1:0] imm);
    exp_q.push_back({st, pcw, adr, mw, irw, rw, res, sa, sb, alu, imm});
    name_q.push_back(nm);
  endtask

  task automatic ex(input string nm, input logic [3:0] st, input logic pcw, input logic adr,
                    input logic mw, input logic irw, input logic rw, input logic [1:0] res,
                    input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
                    input logic [1:0] imm);
    push(nm, st, pcw, adr, mw, irw, rw, res, sa, sb, alu, imm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  initial begin
    reset = 1'b0;
    set_in(RT, 3'b000, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++)
      ex("rst_hold", 4'd0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    reset = 1'b1;
    ex("r_sub_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ex("r_sub_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    ex("r_sub_s6", 4'd6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00);
    ex("r_sub_s7", 4'd7, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    set_in(LW, 3'b010, 1'b0, 1'b0);
    ex("lw_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ex("lw_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    ex("lw_s2", 4'd2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    ex("lw_s3", 4'd3, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    ex("lw_s4", 4'd4, 0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00);

    set_in(SW, 3'b010, 1'b0, 1'b0);
    ex("sw_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    ex("sw_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01);
    ex("sw_s2", 4'd2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01);
    ex("sw_s5", 4'd5, 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);

    set_in(BEQ, 3'b000, 1'b0, 1'b1);
    ex("beq_t_s0",  4'd0,  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10);
    ex("beq_t_s1",  4'd1,  0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10);
    ex("beq_t_s10", 4'd10, 1,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
    zero = 1'b0;
    ex("beq_n_s0",  4'd0,  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10);
    ex("beq_n_s1",  4'd1,  0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10);
    ex("beq_n_s10", 4'd10, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);

    set_in(IA, 3'b000, 1'b1, 1'b0);
    ex("addi_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ex("addi_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    ex("addi_s8", 4'd8, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    ex("addi_s7", 4'd7, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    set_in(RT, 3'b010, 1'b0, 1'b0);
    ex("slt_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ex("slt_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    ex("slt_s6", 4'd6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00);
    ex("slt_s7", 4'd7, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    set_in(RT, 3'b111, 1'b0, 1'b0);
    ex("and_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ex("and_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    ex("and_s6", 4'd6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00);
    funct3 = 3'b110;
    ex("and_s7", 4'd7, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    set_in(RT, 3'b110, 1'b0, 1'b0);
    ex("or_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ex("or_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    ex("or_s6", 4'd6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00);
    ex("or_s7", 4'd7, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    set_in(JAL, 3'b000, 1'b0, 1'b0);
    ex("jal_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11);
    ex("jal_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11);
    ex("jal_s9", 4'd9, 1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11);
    ex("jal_s7", 4'd7, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11);

    set_in(7'b0000000, 3'b000, 1'b0, 1'b0);
    ex("nop_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ex("nop_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);

    set_in(SW, 3'b010, 1'b0, 1'b0);
    ex("swr_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    ex("swr_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01);
    ex("swr_s2", 4'd2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01);
    push("swr_s5", 4'd5, 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    push("rst_in_s5", 4'd0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    -> mon_ev;
    @(posedge clk);
    #1;
    ex("rst_after_s5", 4'd0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    reset = 1'b1;
    ex("rel_s0", 4'd0, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    ex("rel_s1", 4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
